// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, LSB first, one bit per clock,
// using one full-subtractor cell and a borrow flip-flop behind a start/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic d_bit;
    logic brw_nxt;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ brw_q;
        brw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d            = a_q >> 1;
                b_d            = b_q >> 1;
                res_d          = res_q >> 1;
                res_d[WIDTH-1] = d_bit;
                brw_d          = brw_nxt;
                cnt_d          = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    diff_d  = res_d;
                    bout_d  = brw_nxt;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial binary subtractor: computes diff = a - b - bin over WIDTH bits, LSB first, one bit per clock.
- Per-bit datapath is a single full-subtractor cell plus a borrow flip-flop; it is the inverse-operation companion to the team's combinational full adder.
- Sits as a small arithmetic unit behind a start/done handshake, for area-constrained datapaths where latency is acceptable.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; sampled on accepted start
- b  input  WIDTH  subtrahend; sampled on accepted start
- bin  input  1  borrow-in; sampled on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when diff/bout are updated
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
- bout  output  1  final borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: busy=0, done=0, diff=0, bout=0, state=IDLE, internal shift registers, borrow flip-flop and bit counter all 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - latch a into shift register A, b into shift register B, bin into the borrow flip-flop;
  - clear the counter and go to RUN; busy=1 from edge k.
- IDLE, start=0: remain in IDLE; outputs hold.
- RUN, each edge k+1..k+WIDTH, with bit index i = counter:
  - d = A[0] ^ B[0] ^ brw
  - brw_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & brw)
  - shift A and B right by 1; shift d into the MSB of the internal result register; counter += 1.
- Last RUN edge (k+WIDTH, counter == WIDTH-1):
  - copy the completed result register to diff and brw_next to bout;
  - set done=1, busy=0; go to DONE.
- DONE: lasts exactly one cycle. At the next edge: done=0, go to IDLE. start is ignored in DONE.
- Latency: start sampled at edge k gives done high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- diff/bout change only at completion and are stable during RUN; they hold the previous result until the next completion.
- start while busy (RUN) is ignored; it does not restart or corrupt the operation. a/b/bin changing during RUN has no effect.
- reset asserted in any state, including mid-RUN: return to the reset values at that edge. The partial result is discarded and done does not pulse.
- reset and start in the same cycle: reset wins; the operation is not accepted.
- WIDTH=1: RUN lasts one edge; the block behaves as a registered full subtractor.
- Counter width: clog2(WIDTH+1) bits; no wrap-around possible within RUN.
- done and busy are never high in the same cycle.

Test Plan:
- WIDTH=4, reset 2 cycles, then start with a=5, b=3, bin=0 -> busy for 4 cycles; done exactly 4 cycles after start is sampled; diff=2, bout=0.
- WIDTH=4, a=3, b=5, bin=0 -> diff=14, bout=1. Then a=0, b=0, bin=1 -> diff=15, bout=1. Then a=15, b=15, bin=0 -> diff=0, bout=0.
- WIDTH=4, start a=9, b=4; pulse start again with a=1, b=1 two cycles later -> second start ignored; done once; diff=5, bout=0; busy never drops early.
- WIDTH=4, start a=12, b=7; assert reset on the 2nd RUN cycle -> next edge busy=0, done=0, diff=0, bout=0; no done pulse follows. A fresh start a=12, b=7 then gives diff=5.
- WIDTH=1, all 8 combinations of a, b, bin, each started from IDLE -> diff/bout match the full-subtractor truth table (e.g. a=0, b=1, bin=1 -> diff=0, bout=1); done 1 cycle after each start.
- WIDTH=8, 200 random operands, with random start gaps including start during DONE -> every done matches (a - b - bin) mod 256, and bout = (a < b + bin); starts issued during DONE are not accepted.
